// File: rtl/deck_builder.sv
// Lays a 52-card deck into card RAM as a null-terminated linked list starting at BASE_ADDR.
// Define DECK_SHUFFLE_EN to start at seed mod 52 and stride the deck by 7.
module deck_builder #(
  parameter logic [9:0] BASE_ADDR = 10'd256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  seed,
  input  logic        ram_grant,
  output logic        busy,
  output logic        done,
  output logic [9:0]  head_addr,
  output logic [5:0]  card_count,
  output logic [9:0]  ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  c_q, c_d;
  logic [5:0]  count_q, count_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  c_start;
  logic [5:0]  c_sum;

`ifdef DECK_SHUFFLE_EN
  localparam logic [5:0] Step = 6'd7;
  assign c_start = (seed >= 6'd52) ? seed - 6'd52 : seed;
`else
  localparam logic [5:0] Step = 6'd1;
  logic unused_seed;
  assign unused_seed = ^seed;
  assign c_start     = 6'd0;
`endif

  // Suit by range comparison avoids a divider; value is the 1-based rank within the suit.
  function automatic logic [31:0] card_word(input logic [5:0] c, input logic [5:0] k);
    logic [1:0] suit;
    logic [5:0] rem;
    logic [9:0] next;
    if (c >= 6'd39) begin
      suit = 2'd3;
      rem  = c - 6'd39;
    end else if (c >= 6'd26) begin
      suit = 2'd2;
      rem  = c - 6'd26;
    end else if (c >= 6'd13) begin
      suit = 2'd1;
      rem  = c - 6'd13;
    end else begin
      suit = 2'd0;
      rem  = c;
    end
    next = (k == 6'd51) ? 10'd0 : BASE_ADDR + {4'd0, k} + 10'd1;
    return {1'b1, 9'd0, suit, rem[3:0] + 4'd1, 6'd0, next};
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_sum   = c_q + Step;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrite;
          k_d     = 6'd0;
          c_d     = c_start;
          count_d = 6'd0;
          addr_d  = BASE_ADDR;
          data_d  = card_word(c_start, 6'd0);
          busy_d  = 1'b1;
        end
      end
      StWrite: begin
        if (ram_grant) begin
          count_d = count_q + 6'd1;
          if (k_q == 6'd51) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d    = k_q + 6'd1;
            c_d    = (c_sum >= 6'd52) ? c_sum - 6'd52 : c_sum;
            addr_d = addr_q + 10'd1;
            data_d = card_word(c_d, k_q + 6'd1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= 6'd0;
      c_q     <= 6'd0;
      count_q <= 6'd0;
      addr_q  <= 10'd0;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The presented word only commits in a granted cycle, so the enable is gated by the grant.
  assign ram_wren    = busy_q & ram_grant;
  assign busy        = busy_q;
  assign done        = done_q;
  assign head_addr   = BASE_ADDR;
  assign card_count  = count_q;
  assign ram_address = addr_q;
  assign ram_data    = data_q;

endmodule

// File: tb/tb_deck_builder.sv
// Self-checking bench for deck_builder: randomized grant/seed against a slot-order deck model.
module tb_deck_builder;

  localparam logic [9:0] Base = 10'd256;

  logic        clock = 1'b0;
  logic        reset, start, ram_grant;
  logic [5:0]  seed;
  logic        busy, done, ram_wren;
  logic [9:0]  head_addr, ram_address;
  logic [5:0]  card_count;
  logic [31:0] ram_data;

  int errors = 0;
  int checks = 0;

  logic [9:0]  wa[$];
  logic [31:0] wd[$];
  logic        log_busy[256];
  logic        log_wren[256];
  logic [9:0]  log_addr[256];
  logic [5:0]  log_count[256];
  int          done_t;
  int          lows;

  deck_builder #(.BASE_ADDR(Base)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .ram_grant  (ram_grant),
    .busy       (busy),
    .done       (done),
    .head_addr  (head_addr),
    .card_count (card_count),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren)
  );

  always #5 clock = ~clock;

  // Card index dealt into slot k.
  function automatic int exp_c(int sd, int k);
`ifdef DECK_SHUFFLE_EN
    return ((sd % 52) + 7 * k) % 52;
`else
    return k + 0 * sd;
`endif
  endfunction

  function automatic logic [31:0] exp_word(int c, int k);
    int suit = c / 13;
    int val  = c % 13 + 1;
    int nxt  = (k == 51) ? 0 : int'(Base) + k + 1;
    return {1'b1, 9'd0, 2'(suit), 4'(val), 6'd0, 10'(nxt)};
  endfunction

  // grant_mode: 0 always, 1 three-cycle stall at slot 10, 2 random.
  // start_mode: 0 pulse, 1 re-pulse during WRITE, 2 held high.
  task automatic capture(input int grant_mode, input int start_mode, input logic [5:0] sd);
    int t = 0;
    int stall_left = 0;
    bit stalled = 0;
    wa.delete();
    wd.delete();
    done_t = -1;
    lows   = 0;
    @(posedge clock);
    #2;
    seed      = sd;
    start     = 1'b1;
    ram_grant = 1'b1;
    while (t < 250 && done_t < 0) begin
      @(posedge clock);
      #1;
      t++;
      if (start_mode == 0) start = 1'b0;
      else if (start_mode == 1) start = (t >= 20 && t <= 22);
      if (grant_mode == 1) begin
        if (!stalled && busy && ram_address == Base + 10) begin
          stalled    = 1;
          stall_left = 3;
        end
        ram_grant = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else if (grant_mode == 2) begin
        ram_grant = ($urandom_range(0, 3) != 0);
      end else begin
        ram_grant = 1'b1;
      end
      #1;
      log_busy[t]  = busy;
      log_wren[t]  = ram_wren;
      log_addr[t]  = ram_address;
      log_count[t] = card_count;
      if (busy && !ram_grant) lows++;
      if (ram_wren) begin
        wa.push_back(ram_address);
        wd.push_back(ram_data);
      end
      if (done) done_t = t;
    end
    if (done_t < 0) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: done not seen within %0d cycles", t);
      done_t = 0;
    end
    ram_grant = 1'b1;
    if (start_mode != 2) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ram_grant = 1'b1; seed = 6'd0;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if ({busy, done, ram_wren, ram_address, ram_data, card_count} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b wren=%b addr=%h data=%h count=%0d",
               busy, done, ram_wren, ram_address, ram_data, card_count);
    end
    checks++;
    if (head_addr !== Base) begin
      errors++;
      $display("FAIL reset_head: got %h want %h", head_addr, Base);
    end
    reset = 1'b0;
  endtask

  task automatic test_sorted();
    capture(0, 0, 6'd0);
    checks++;
    if (done_t != 53 || wa.size() != 52) begin
      errors++;
      $display("FAIL sorted_timing: done cycle %0d writes %0d, want 53 and 52", done_t, wa.size());
    end
    checks++;
    if (log_busy[1] !== 1'b1 || log_busy[done_t] !== 1'b0 || log_count[done_t] !== 6'd52) begin
      errors++;
      $display("FAIL sorted_flags: busy1=%b busy_done=%b count=%0d, want 1 0 52",
               log_busy[1], log_busy[done_t], log_count[done_t]);
    end
    for (int k = 0; k < 52; k++) begin
      checks++;
      if (k >= wa.size() || wa[k] !== Base + 10'(k) || wd[k] !== exp_word(exp_c(0, k), k)) begin
        errors++;
        $display("FAIL sorted_slot%0d: got %h/%h want %h/%h", k,
                 (k < wa.size()) ? wa[k] : 10'h3ff, (k < wd.size()) ? wd[k] : 32'hx,
                 Base + 10'(k), exp_word(exp_c(0, k), k));
      end
    end
`ifndef DECK_SHUFFLE_EN
    checks++;
    if (wa.size() != 52 || wd[0] !== 32'h80010101 || wd[13] !== 32'h8011010E ||
        wa[51] !== 10'h133 || wd[51] !== 32'h803D0000) begin
      errors++;
      $display("FAIL sorted_fixed: got %h %h %h %h", (wd.size() > 0) ? wd[0] : 32'hx,
               (wd.size() > 13) ? wd[13] : 32'hx, (wa.size() > 51) ? wa[51] : 10'hx,
               (wd.size() > 51) ? wd[51] : 32'hx);
    end
`endif
  endtask

  task automatic test_stall();
    capture(1, 0, 6'd3);
    checks++;
    if (done_t != 56 || wa.size() != 52) begin
      errors++;
      $display("FAIL stall_timing: done cycle %0d writes %0d, want 56 and 52", done_t, wa.size());
    end
    for (int t = 11; t <= 13; t++) begin
      checks++;
      if (log_wren[t] !== 1'b0 || log_addr[t] !== 10'h10A) begin
        errors++;
        $display("FAIL stall_hold%0d: wren=%b addr=%h want 0 10a", t, log_wren[t], log_addr[t]);
      end
    end
    checks++;
    if (wa.size() < 11 || wa[10] !== 10'h10A || wd[10] !== exp_word(exp_c(3, 10), 10)) begin
      errors++;
      $display("FAIL stall_slot10: got %h want %h", (wd.size() > 10) ? wd[10] : 32'hx,
               exp_word(exp_c(3, 10), 10));
    end
  endtask

  task automatic test_start_during_write();
    capture(0, 1, 6'd0);
    checks++;
    if (done_t != 53 || wa.size() != 52) begin
      errors++;
      $display("FAIL restart_ignored: done cycle %0d writes %0d, want 53 and 52", done_t, wa.size());
    end
    repeat (2) begin
      @(posedge clock);
      #2;
      checks++;
      if (busy !== 1'b0 || ram_wren !== 1'b0) begin
        errors++;
        $display("FAIL restart_idle: busy=%b wren=%b want 0 0", busy, ram_wren);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(posedge clock);
    #2;
    start = 1'b1;
    @(posedge clock);
    #2;
    start = 1'b0;
    while (!(busy && ram_address == Base + 20) && n < 60) begin
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL reset_mid_reach: slot 20 not presented, addr=%h", ram_address);
    end
    reset = 1'b1;
    @(posedge clock);
    #2;
    checks++;
    if (busy !== 1'b0 || ram_wren !== 1'b0 || card_count !== 6'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b wren=%b count=%0d done=%b want 0 0 0 0",
               busy, ram_wren, card_count, done);
    end
    reset = 1'b0;
    capture(0, 0, 6'd9);
    checks++;
    if (done_t != 53 || wa.size() != 52 || wa[0] !== Base || wd[0] !== exp_word(exp_c(9, 0), 0)) begin
      errors++;
      $display("FAIL reset_rebuild: done cycle %0d writes %0d, want 53 and 52 from slot 0",
               done_t, wa.size());
    end
  endtask

  task automatic test_random_grant();
    logic [5:0] sd;
    repeat (3) begin
      sd = 6'($urandom_range(0, 63));
      capture(2, 0, sd);
      checks++;
      if (done_t != 53 + lows || wa.size() != 52) begin
        errors++;
        $display("FAIL rand_timing: done cycle %0d want %0d, writes %0d", done_t, 53 + lows,
                 wa.size());
      end
      for (int k = 0; k < 52; k++) begin
        checks++;
        if (k >= wa.size() || wa[k] !== Base + 10'(k) || wd[k] !== exp_word(exp_c(sd, k), k)) begin
          errors++;
          $display("FAIL rand_slot%0d: seed %0d got %h want %h", k, sd,
                   (k < wd.size()) ? wd[k] : 32'hx, exp_word(exp_c(sd, k), k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    capture(0, 2, 6'd0);
    checks++;
    if (done_t != 53) begin
      errors++;
      $display("FAIL b2b_first: done cycle %0d want 53", done_t);
    end
    @(posedge clock);
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clock);
    #2;
    checks++;
    if (busy !== 1'b1 || ram_address !== Base || card_count !== 6'd0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b addr=%h count=%0d want 1 %h 0", busy, ram_address,
               card_count, Base);
    end
    start = 1'b0;
    while (!done && n < 60) begin
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (n != 52) begin
      errors++;
      $display("FAIL b2b_second: done after %0d cycles want 52", n);
    end
  endtask

`ifdef DECK_SHUFFLE_EN
  task automatic test_shuffle();
    logic [5:0] seeds[3];
    bit seen[52];
    seeds[0] = 6'd5;
    seeds[1] = 6'd60;
    seeds[2] = 6'($urandom_range(0, 63));
    for (int s = 0; s < 3; s++) begin
      capture(0, 0, seeds[s]);
      foreach (seen[i]) seen[i] = 0;
      for (int k = 0; k < 52; k++) begin
        checks++;
        if (k >= wd.size() || wd[k] !== exp_word(exp_c(seeds[s], k), k)) begin
          errors++;
          $display("FAIL shuf_slot%0d: seed %0d got %h want %h", k, seeds[s],
                   (k < wd.size()) ? wd[k] : 32'hx, exp_word(exp_c(seeds[s], k), k));
        end else begin
          seen[int'(wd[k][21:20]) * 13 + int'(wd[k][19:16]) - 1] = 1;
        end
      end
      checks++;
      if (seen.sum() with (int'(item)) != 52) begin
        errors++;
        $display("FAIL shuf_unique: seed %0d distinct cards %0d want 52", seeds[s],
                 seen.sum() with (int'(item)));
      end
      if (s == 0) begin
        checks++;
        if (wd.size() < 2 || wd[0] !== 32'h80060101 || wd[1] !== 32'h800D0102) begin
          errors++;
          $display("FAIL shuf_seed5: got %h %h want 80060101 800d0102",
                   (wd.size() > 0) ? wd[0] : 32'hx, (wd.size() > 1) ? wd[1] : 32'hx);
        end
      end else if (s == 1) begin
        checks++;
        if (wd.size() < 1 || wd[0] !== 32'h80090101) begin
          errors++;
          $display("FAIL shuf_seed60: got %h want 80090101", (wd.size() > 0) ? wd[0] : 32'hx);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sorted();
    test_stall();
    test_start_during_write();
    test_reset_mid();
    test_random_grant();
    test_back_to_back();
`ifdef DECK_SHUFFLE_EN
    test_shuffle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
